// File: rtl/cajero_arbitro_saldo_pkg.sv
// Shared types for the ATM balance arbiter: service FSM states and
// transaction-type encodings.
package cajero_arbitro_saldo_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CAPTURA   = 2'd1,
    EJECUTA   = 2'd2,
    RESPUESTA = 2'd3
  } estado_e;

  localparam logic TIPO_DEPOSITO = 1'b0;
  localparam logic TIPO_RETIRO   = 1'b1;

endpackage

// File: rtl/cajero_arbitro_saldo_arbitro_rr.sv
// Combinational round-robin picker: the first set request at or after ptr_i
// wins. The pointer register itself lives in the caller.
module arbitro_rr
  import cajero_arbitro_saldo_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand;

  // Scan from the lowest priority offset down, so offset 0 is written last and wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    cand  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr_i) + k) % N_REQ);
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/cajero_arbitro_saldo.sv
// Shares one account balance among N_REQ ATM front-ends: round-robin grant,
// one transaction in flight, atomic read-modify-write of the balance.
module cajero_arbitro_saldo
  import cajero_arbitro_saldo_pkg::*;
#(
  parameter int              N_REQ     = 2,
  parameter int              BAL_W     = 64,
  parameter int              AMT_W     = 32,
  parameter logic [BAL_W-1:0] BAL_RESET = BAL_W'(20000)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   bal_load_i,
  input  logic [BAL_W-1:0]       balance_inicial_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ-1:0]       tipo_trans_i,
  input  logic [N_REQ*AMT_W-1:0] monto_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       done_o,
  output logic [N_REQ-1:0]       rechazo_o,
  output logic [BAL_W-1:0]       balance_o,
  output logic                   ocupado_o,
  output logic [15:0]            n_trans_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  estado_e          estado_q, estado_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             tipo_q, tipo_d;
  logic [BAL_W-1:0] monto_q, monto_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic [15:0]      n_trans_q, n_trans_d;
  logic             ok_q, ok_d;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;
  logic [AMT_W-1:0] monto_sel;
  logic [BAL_W:0]   suma;
  logic [BAL_W-1:0] resultado;
  logic             rechazar;

  arbitro_rr #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arbitro_rr (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    monto_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_q == IDX_W'(i)) monto_sel = monto_i[i*AMT_W +: AMT_W];
    end
  end

  // Deposit overflow shows up as the carry out of a one-bit-wider sum.
  always_comb begin
    suma = {1'b0, balance_q} + {1'b0, monto_q};
    if (tipo_q == TIPO_DEPOSITO) begin
      rechazar  = suma[BAL_W];
      resultado = suma[BAL_W-1:0];
    end else begin
      rechazar  = (monto_q > balance_q);
      resultado = balance_q - monto_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado_q <= IDLE;
    else        estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      IDLE:      if (!bal_load_i && arb_valid) estado_d = CAPTURA;
      CAPTURA:   estado_d = EJECUTA;
      EJECUTA:   estado_d = RESPUESTA;
      RESPUESTA: estado_d = IDLE;
      default:   estado_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d     = ptr_q;
    win_d     = win_q;
    gnt_d     = gnt_q;
    tipo_d    = tipo_q;
    monto_d   = monto_q;
    balance_d = balance_q;
    n_trans_d = n_trans_q;
    ok_d      = ok_q;
    case (estado_q)
      IDLE: begin
        if (bal_load_i) begin
          balance_d = balance_inicial_i;
        end else if (arb_valid) begin
          win_d = arb_idx;
          gnt_d = arb_gnt;
        end
      end
      CAPTURA: begin
        tipo_d  = tipo_trans_i[win_q];
        monto_d = BAL_W'(monto_sel);
      end
      EJECUTA: begin
        ok_d = !rechazar;
        if (!rechazar) begin
          balance_d = resultado;
          n_trans_d = n_trans_q + 16'd1;
        end
      end
      RESPUESTA: begin
        gnt_d = '0;
        ptr_d = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      win_q     <= '0;
      gnt_q     <= '0;
      tipo_q    <= TIPO_DEPOSITO;
      monto_q   <= '0;
      balance_q <= BAL_RESET;
      n_trans_q <= '0;
      ok_q      <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      gnt_q     <= gnt_d;
      tipo_q    <= tipo_d;
      monto_q   <= monto_d;
      balance_q <= balance_d;
      n_trans_q <= n_trans_d;
      ok_q      <= ok_d;
    end
  end

  always_comb begin
    gnt_o     = gnt_q;
    done_o    = '0;
    rechazo_o = '0;
    if (estado_q == RESPUESTA) begin
      if (ok_q) done_o    = gnt_q;
      else      rechazo_o = gnt_q;
    end
    ocupado_o = (estado_q != IDLE);
    balance_o = balance_q;
    n_trans_o = n_trans_q;
  end

endmodule

// File: tb/tb_cajero_arbitro_saldo.sv
// Randomized self-checking bench for cajero_arbitro_saldo against an
// account-level reference model (balance, commit count, round-robin pointer).
module tb_cajero_arbitro_saldo;

  localparam int N_REQ = 2;
  localparam int BAL_W = 64;
  localparam int AMT_W = 32;
  localparam logic [63:0] MAX_BAL = 64'hFFFF_FFFF_FFFF_FFFF;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   balLoad;
  logic [BAL_W-1:0]       balanceInicial;
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       tipoTrans;
  logic [N_REQ*AMT_W-1:0] montoBus;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic [N_REQ-1:0]       rechazo;
  logic [BAL_W-1:0]       balance;
  logic                   ocupado;
  logic [15:0]            nTrans;

  int          nChecks = 0;
  int          nFails  = 0;
  logic [63:0] modelBal;
  logic [15:0] modelTrans;
  int          modelPtr;

  cajero_arbitro_saldo #(
    .N_REQ (N_REQ),
    .BAL_W (BAL_W),
    .AMT_W (AMT_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bal_load_i        (balLoad),
    .balance_inicial_i (balanceInicial),
    .req_i             (req),
    .tipo_trans_i      (tipoTrans),
    .monto_i           (montoBus),
    .gnt_o             (gnt),
    .done_o            (done),
    .rechazo_o         (rechazo),
    .balance_o         (balance),
    .ocupado_o         (ocupado),
    .n_trans_o         (nTrans)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Account rules: a withdrawal needs enough funds, a deposit must fit under the maximum.
  task automatic modelApply(input int who, input bit tipo, input logic [63:0] amt, output bit ok);
    if (tipo) ok = (amt <= modelBal);
    else      ok = (amt <= MAX_BAL - modelBal);
    if (ok) begin
      modelBal   = tipo ? modelBal - amt : modelBal + amt;
      modelTrans = modelTrans + 16'd1;
    end
    modelPtr = (who + 1) % N_REQ;
  endtask

  function automatic int pickWinner(input logic [N_REQ-1:0] mask, input int ptr);
    for (int k = 0; k < N_REQ; k++) begin
      if (mask[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    end
    return 0;
  endfunction

  task automatic setLane(input int who, input bit tipo, input logic [31:0] amt);
    tipoTrans[who] = tipo;
    montoBus[who*AMT_W +: AMT_W] = amt;
  endtask

  task automatic applyLoad(input logic [63:0] value);
    @(negedge clk);
    balLoad = 1'b1;
    balanceInicial = value;
    @(negedge clk);
    balLoad = 1'b0;
    modelBal = value;
    checkOutput("balLoad", balance, modelBal);
    checkOutput("loadNoGnt", {ocupado, gnt}, 0);
  endtask

  // Single-requester transaction; REQ and the lane are scrambled after capture.
  task automatic applyStimulus(input int who, input bit tipo, input logic [31:0] amt, input bit loadWhileBusy);
    bit ok;
    int cycles;
    logic [N_REQ-1:0] oneHot;
    oneHot = N_REQ'(1) << who;
    @(negedge clk);
    setLane(who, tipo, amt);
    req[who] = 1'b1;
    modelApply(who, tipo, {32'b0, amt}, ok);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        checkOutput("gntCaptura", gnt, oneHot);
        if (loadWhileBusy) begin
          balLoad = 1'b1;
          balanceInicial = 64'h1234_5678;
        end
      end
      if (cycles == 2) begin
        req[who] = 1'b0;
        setLane(who, ~tipo, ~amt);
        balLoad = 1'b0;
      end
    end while ((done | rechazo) == 0 && cycles < 12);
    req = '0;
    balLoad = 1'b0;
    checkOutput("latency", cycles, 3);
    checkOutput("done", done, ok ? oneHot : '0);
    checkOutput("rechazo", rechazo, ok ? '0 : oneHot);
    checkOutput("gntRespuesta", gnt, oneHot);
    checkOutput("balance", balance, modelBal);
    checkOutput("nTrans", nTrans, modelTrans);
    @(negedge clk);
    checkOutput("pulseEnd", {done, rechazo}, 0);
    checkOutput("ocupadoIdle", ocupado, 0);
  endtask

  task automatic runContention(input logic [N_REQ-1:0] mask, input int nServ);
    int served;
    int cycles;
    int expW;
    bit ok;
    served = 0;
    cycles = 0;
    @(negedge clk);
    req = mask;
    while (served < nServ && cycles < nServ * 8) begin
      @(negedge clk);
      cycles++;
      checkOutput("gntOneHot", ($countones(gnt) <= 1), 1);
      if ((done | rechazo) != 0) begin
        expW = pickWinner(mask, modelPtr);
        modelApply(expW, tipoTrans[expW], {32'b0, montoBus[expW*AMT_W +: AMT_W]}, ok);
        checkOutput("rrOrder", done | rechazo, N_REQ'(1) << expW);
        checkOutput("rrOutcome", done, ok ? (N_REQ'(1) << expW) : '0);
        checkOutput("rrBalance", balance, modelBal);
        checkOutput("rrNTrans", nTrans, modelTrans);
        served++;
        if (served == nServ) req = '0;
      end
    end
    req = '0;
    checkOutput("rrServed", served, nServ);
    @(negedge clk);
    checkOutput("rrIdle", ocupado, 0);
  endtask

  initial begin
    bit sawPulse;
    int r;
    rst_n = 1'b0;
    balLoad = 1'b0;
    balanceInicial = '0;
    req = '0;
    tipoTrans = '0;
    montoBus = '0;
    modelBal = 64'd20000;
    modelTrans = 16'd0;
    modelPtr = 0;

    repeat (2) @(negedge clk);
    checkOutput("rstBalance", balance, 64'd20000);
    checkOutput("rstOutputs", {gnt, done, rechazo, ocupado}, 0);
    checkOutput("rstNTrans", nTrans, 0);
    rst_n = 1'b1;

    applyStimulus(0, 1'b0, 32'd15000, 1'b0);
    applyStimulus(1, 1'b1, 32'd15000, 1'b0);
    applyStimulus(0, 1'b1, 32'd45000, 1'b0);
    applyStimulus(0, 1'b1, 32'd10000, 1'b0);

    setLane(0, 1'b0, 32'd1);
    setLane(1, 1'b0, 32'd1);
    runContention(2'b11, 4);

    applyStimulus(1, 1'b1, modelBal[31:0], 1'b0);
    checkOutput("exactZero", balance, 0);
    applyLoad(MAX_BAL - 64'd4);
    applyStimulus(0, 1'b0, 32'd10, 1'b0);
    applyStimulus(1, 1'b0, 32'd0, 1'b0);
    applyStimulus(0, 1'b1, 32'd5, 1'b1);

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        applyLoad(($urandom_range(0, 1) == 1) ? {32'hFFFF_FFFF, $urandom} : {32'b0, $urandom});
      end else if (r < 4) begin
        for (int i = 0; i < N_REQ; i++) setLane(i, 1'($urandom_range(0, 1)), $urandom_range(0, 70000));
        runContention(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), $urandom_range(1, 4));
      end else begin
        applyStimulus($urandom_range(0, N_REQ - 1), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 50000), 1'b0);
      end
    end

    // Abort a transaction in EJECUTA with an asynchronous reset.
    @(negedge clk);
    setLane(0, 1'b0, 32'd500);
    req[0] = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("busyBeforeReset", ocupado, 1);
    req = '0;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncOcupado", ocupado, 0);
    checkOutput("asyncBalance", balance, 64'd20000);
    checkOutput("asyncGnt", gnt, 0);
    checkOutput("asyncNTrans", nTrans, 0);
    modelBal = 64'd20000;
    modelTrans = 16'd0;
    modelPtr = 0;
    sawPulse = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      if ((done | rechazo) != 0) sawPulse = 1'b1;
    end
    checkOutput("noPulseAfterAbort", sawPulse, 0);
    checkOutput("balanceAfterAbort", balance, 64'd20000);

    setLane(0, 1'b0, 32'd1);
    setLane(1, 1'b0, 32'd1);
    runContention(2'b11, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
